// File: rtl/dlx_mem_pkg.sv
// Shared types and defaults for the DLX data-memory arbitration controller.
package dlx_mem_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} memctl_state_t;

    typedef logic port_idx_t;

    localparam int unsigned DEF_DATA_DELAY = 2;
    localparam int unsigned DEF_TIMEOUT    = 16;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick; on a tie the port that did not win last time is chosen.
module rr_arbiter2
    import dlx_mem_pkg::*;
(
    input  logic      valid0,
    input  logic      valid1,
    input  port_idx_t last_grant,
    output port_idx_t grant,
    output logic      any_valid
);

    always_comb begin
        any_valid = valid0 | valid1;
        if (valid0 && valid1) begin
            grant = ~last_grant;
        end else if (valid1) begin
            grant = 1'b1;
        end else begin
            grant = 1'b0;
        end
    end

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Shares the single DLX data memory between instruction fetch (port 0) and load/store (port 1),
// round-robin, with a fixed data delay gate and a timeout abort.
module mem_arbiter_ctrl
    import dlx_mem_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = 32,
    parameter int unsigned ADDRESS_SIZE = 16,
    parameter int unsigned DATA_DELAY   = DEF_DATA_DELAY,
    parameter int unsigned TIMEOUT      = DEF_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0_valid,
    input  logic                    req0_rnw,
    input  logic [ADDRESS_SIZE-1:0] req0_addr,
    input  logic [WORD_SIZE-1:0]    req0_wdata,
    output logic                    req0_done,
    output logic [WORD_SIZE-1:0]    req0_rdata,
    output logic                    req0_err,
    input  logic                    req1_valid,
    input  logic                    req1_rnw,
    input  logic [ADDRESS_SIZE-1:0] req1_addr,
    input  logic [WORD_SIZE-1:0]    req1_wdata,
    output logic                    req1_done,
    output logic [WORD_SIZE-1:0]    req1_rdata,
    output logic                    req1_err,
    output logic                    mem_enable,
    output logic                    mem_readnotwrite,
    output logic [ADDRESS_SIZE-1:0] mem_address,
    output logic [WORD_SIZE-1:0]    mem_wdata,
    output logic                    mem_wdata_oe,
    input  logic [WORD_SIZE-1:0]    mem_rdata,
    input  logic                    mem_data_ready
);

    localparam int unsigned         CNT_W     = $clog2(TIMEOUT + 2);
    localparam logic [CNT_W-1:0]    DELAY_C   = CNT_W'(DATA_DELAY);
    localparam logic [CNT_W-1:0]    TIMEOUT_C = CNT_W'(TIMEOUT);

    memctl_state_t             state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    port_idx_t                 last_q, last_d;
    port_idx_t                 gnt_q, gnt_d;
    port_idx_t                 arb_grant;
    logic                      arb_any;
    logic                      rnw_q, rnw_d;
    logic [ADDRESS_SIZE-1:0]   addr_q, addr_d;
    logic [WORD_SIZE-1:0]      wdata_q, wdata_d;
    logic                      enable_q, enable_d;
    logic                      oe_q, oe_d;
    logic [1:0]                done_q, done_d;
    logic [1:0]                err_q, err_d;
    logic [WORD_SIZE-1:0]      rdata_q [2];
    logic [WORD_SIZE-1:0]      rdata_d [2];

    rr_arbiter2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_q),
        .grant      (arb_grant),
        .any_valid  (arb_any)
    );

    // Memory-side outputs are computed one cycle ahead so every port is driven straight from a flop.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        gnt_d    = gnt_q;
        rnw_d    = rnw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        enable_d = 1'b0;
        oe_d     = 1'b0;
        done_d   = '0;
        err_d    = err_q;
        rdata_d  = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    gnt_d    = arb_grant;
                    last_d   = arb_grant;
                    rnw_d    = arb_grant ? req1_rnw   : req0_rnw;
                    addr_d   = arb_grant ? req1_addr  : req0_addr;
                    wdata_d  = arb_grant ? req1_wdata : req0_wdata;
                    cnt_d    = CNT_W'(1);
                    enable_d = 1'b1;
                    oe_d     = ~rnw_d;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                cnt_d    = cnt_q + CNT_W'(1);
                enable_d = 1'b1;
                oe_d     = ~rnw_q;
                // DATA_READY is sticky in the memory, so it is ignored until the delay has elapsed.
                if (cnt_q >= DELAY_C && mem_data_ready) begin
                    enable_d       = 1'b0;
                    oe_d           = 1'b0;
                    done_d[gnt_q]  = 1'b1;
                    err_d[gnt_q]   = 1'b0;
                    if (rnw_q) begin
                        rdata_d[gnt_q] = mem_rdata;
                    end
                    state_d = DONE;
                end else if (cnt_q == TIMEOUT_C) begin
                    enable_d       = 1'b0;
                    oe_d           = 1'b0;
                    done_d[gnt_q]  = 1'b1;
                    err_d[gnt_q]   = 1'b1;
                    rdata_d[gnt_q] = '0;
                    state_d        = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= 1'b1;
            gnt_q      <= 1'b0;
            rnw_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            enable_q   <= 1'b0;
            oe_q       <= 1'b0;
            done_q     <= '0;
            err_q      <= '0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            rnw_q      <= rnw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            enable_q   <= enable_d;
            oe_q       <= oe_d;
            done_q     <= done_d;
            err_q      <= err_d;
            rdata_q[0] <= rdata_d[0];
            rdata_q[1] <= rdata_d[1];
        end
    end

    assign mem_enable       = enable_q;
    assign mem_wdata_oe     = oe_q;
    assign mem_readnotwrite = rnw_q;
    assign mem_address      = addr_q;
    assign mem_wdata        = wdata_q;
    assign req0_done        = done_q[0];
    assign req1_done        = done_q[1];
    assign req0_err         = err_q[0];
    assign req1_err         = err_q[1];
    assign req0_rdata       = rdata_q[0];
    assign req1_rdata       = rdata_q[1];

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Self-checking bench for mem_arbiter_ctrl: directed scenarios plus randomized traffic
// checked against a transaction-level reference model.
module tb_mem_arbiter_ctrl;

    localparam int WS = 32;
    localparam int AS = 16;
    localparam int DD = 2;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    rq_valid = '0;
    logic [1:0]    rq_rnw   = '0;
    logic [AS-1:0] rq_addr  [2];
    logic [WS-1:0] rq_wdata [2];

    logic          req0_done, req1_done, req0_err, req1_err;
    logic [WS-1:0] req0_rdata, req1_rdata;
    logic          mem_enable, mem_readnotwrite, mem_wdata_oe, mem_data_ready;
    logic [AS-1:0] mem_address;
    logic [WS-1:0] mem_wdata, mem_rdata;

    logic [1:0]    dut_done;
    logic [1:0]    dut_err;
    logic [WS-1:0] dut_rdata [2];

    assign dut_done     = {req1_done, req0_done};
    assign dut_err      = {req1_err, req0_err};
    assign dut_rdata[0] = req0_rdata;
    assign dut_rdata[1] = req1_rdata;

    mem_arbiter_ctrl #(
        .WORD_SIZE    (WS),
        .ADDRESS_SIZE (AS),
        .DATA_DELAY   (DD),
        .TIMEOUT      (TO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req0_valid       (rq_valid[0]),
        .req0_rnw         (rq_rnw[0]),
        .req0_addr        (rq_addr[0]),
        .req0_wdata       (rq_wdata[0]),
        .req0_done        (req0_done),
        .req0_rdata       (req0_rdata),
        .req0_err         (req0_err),
        .req1_valid       (rq_valid[1]),
        .req1_rnw         (rq_rnw[1]),
        .req1_addr        (rq_addr[1]),
        .req1_wdata       (rq_wdata[1]),
        .req1_done        (req1_done),
        .req1_rdata       (req1_rdata),
        .req1_err         (req1_err),
        .mem_enable       (mem_enable),
        .mem_readnotwrite (mem_readnotwrite),
        .mem_address      (mem_address),
        .mem_wdata        (mem_wdata),
        .mem_wdata_oe     (mem_wdata_oe),
        .mem_rdata        (mem_rdata),
        .mem_data_ready   (mem_data_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [WS-1:0] init_word(input logic [AS-1:0] a);
        if (a == 16'h0010) return 32'hDEADBEEF;
        return {a, ~a} ^ 32'h5A5A_0000;
    endfunction

    // Memory: sticky DATA_READY that rises after cur_lat enabled cycles; writes land when ready.
    bit [WS-1:0] mem_arr  [0:65535];
    bit          wr_valid [0:65535];
    int          cur_lat = 0;
    int          en_run  = 0;

    always @(posedge clk) begin
        if (mem_enable) en_run <= en_run + 1;
        else            en_run <= 0;
        if (mem_enable && !mem_readnotwrite && mem_wdata_oe && mem_data_ready) begin
            mem_arr[mem_address]  <= mem_wdata;
            wr_valid[mem_address] <= 1'b1;
        end
    end

    assign mem_data_ready = mem_enable && (en_run + 1 >= cur_lat);
    assign mem_rdata      = wr_valid[mem_address] ? mem_arr[mem_address] : init_word(mem_address);

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [WS-1:0] got, input logic [WS-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: one transaction at a time, length derived from the memory latency.
    logic [WS-1:0] ref_mem [logic [AS-1:0]];
    bit            m_act = 0, m_port = 0, m_last = 1, m_rnw = 0, m_err = 0, m_done_now = 0;
    int            m_s = 0, m_L = 0;
    logic [AS-1:0] m_addr = '0;
    logic [WS-1:0] m_wd = '0;
    logic [WS-1:0] exp_rdata [2];
    bit   [1:0]    exp_err = '0;
    int            nxt_lat [2];
    bit   [1:0]    pend = '0;
    bit            auto_req = 0;
    int            cyc = 0;

    function automatic logic [WS-1:0] ref_rd(input logic [AS-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic model_reset();
        m_act = 0; m_last = 1; m_done_now = 0;
        exp_rdata[0] = '0; exp_rdata[1] = '0; exp_err = '0;
    endtask

    task automatic model_edge();
        m_done_now = 0;
        if (m_act) begin
            m_s++;
            if (m_s == m_L) begin
                m_done_now = 1;
                if (m_err)      exp_rdata[m_port] = '0;
                else if (m_rnw) exp_rdata[m_port] = ref_rd(m_addr);
                else            ref_mem[m_addr] = m_wd;
                exp_err[m_port] = m_err;
            end else if (m_s == m_L + 1) begin
                m_act = 0;
            end
        end else if (rq_valid != 2'b00) begin
            m_port  = (rq_valid == 2'b11) ? ~m_last : rq_valid[1];
            m_last  = m_port;
            m_act   = 1;
            m_s     = 0;
            m_rnw   = rq_rnw[m_port];
            m_addr  = rq_addr[m_port];
            m_wd    = rq_wdata[m_port];
            cur_lat = nxt_lat[m_port];
            m_err   = cur_lat > TO;
            m_L     = m_err ? TO : ((cur_lat < DD) ? DD : cur_lat);
        end
    endtask

    task automatic check_cycle();
        bit exp_en;
        exp_en = m_act && (m_s < m_L);
        for (int p = 0; p < 2; p++) begin
            check($sformatf("done%0d", p), dut_done[p], (m_done_now && m_port == p));
            check($sformatf("rdata%0d", p), dut_rdata[p], exp_rdata[p]);
            if (m_done_now && m_port == p) check($sformatf("err%0d", p), dut_err[p], exp_err[p]);
        end
        check("mem_enable", mem_enable, exp_en);
        check("mem_wdata_oe", mem_wdata_oe, exp_en && !m_rnw);
        if (exp_en) begin
            check("mem_address", mem_address, m_addr);
            check("mem_readnotwrite", mem_readnotwrite, m_rnw);
            if (!m_rnw) check("mem_wdata", mem_wdata, m_wd);
        end
    endtask

    function automatic int rand_lat();
        int tbl [8] = '{0, 1, 2, 2, 3, 5, 16, 40};
        return tbl[$urandom_range(0, 7)];
    endfunction

    function automatic logic [AS-1:0] rand_addr();
        logic [AS-1:0] tbl [6] = '{16'h0000, 16'h0010, 16'h0020, 16'h1234, 16'h7FFF, 16'hFFFF};
        return tbl[$urandom_range(0, 5)];
    endfunction

    task automatic issue(input int p, input bit rnw, input logic [AS-1:0] a,
                         input logic [WS-1:0] wd, input int lat);
        pend[p]     = 1;
        rq_valid[p] = 1'b1;
        rq_rnw[p]   = rnw;
        rq_addr[p]  = a;
        rq_wdata[p] = wd;
        nxt_lat[p]  = lat;
    endtask

    task automatic drive_requesters();
        for (int p = 0; p < 2; p++) begin
            if (m_done_now && m_port == p) begin
                pend[p]     = 0;
                rq_valid[p] = 1'b0;
            end else if (auto_req && pend[p] && rq_valid[p] && m_act && m_port == p
                         && $urandom_range(0, 7) == 0) begin
                // Dropping valid and scrambling inputs after grant must not disturb the transaction.
                rq_valid[p] = 1'b0;
                rq_rnw[p]   = $urandom_range(0, 1) == 1;
                rq_addr[p]  = AS'($urandom);
                rq_wdata[p] = $urandom;
            end
            if (auto_req && !pend[p] && $urandom_range(0, 3) == 0)
                issue(p, $urandom_range(0, 1) == 1, rand_addr(), $urandom, rand_lat());
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (rst) model_reset();
        else     model_edge();
        #1;
        if (!rst) begin
            check_cycle();
            drive_requesters();
        end
    endtask

    task automatic wait_done(input int p, input int budget, output int n);
        n = 0;
        while (n < budget) begin
            step();
            n++;
            if (dut_done[p]) return;
        end
        check($sformatf("done%0d_within_%0d", p, budget), dut_done[p], 1'b1);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((pend != 2'b00 || m_act) && k < budget) begin
            step();
            k++;
        end
        if (pend != 2'b00 || m_act) check("drain_budget", {30'd0, pend}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_enable"}, mem_enable, 1'b0);
        check({tag, "_oe"}, mem_wdata_oe, 1'b0);
        check({tag, "_rnw"}, mem_readnotwrite, 1'b0);
        check({tag, "_addr"}, mem_address, '0);
        check({tag, "_wdata"}, mem_wdata, '0);
        check({tag, "_done"}, dut_done, '0);
        check({tag, "_err"}, dut_err, '0);
        check({tag, "_rdata0"}, req0_rdata, '0);
        check({tag, "_rdata1"}, req1_rdata, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, first_port, last_cyc, got;
        rq_addr[0] = '0; rq_addr[1] = '0; rq_wdata[0] = '0; rq_wdata[1] = '0;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        nxt_lat[0] = DD; nxt_lat[1] = DD;

        // Asynchronous reset before any clock edge.
        #3 rst = 1'b1;
        #1 check_all_zero("reset_async");
        step(); step();
        @(negedge clk) rst = 1'b0;

        // First tie after reset goes to port 0, then port 1 four cycles later.
        issue(0, 1'b1, 16'h0010, '0, DD);
        issue(1, 1'b1, 16'h0020, '0, DD);
        wait_done(0, 10, n);
        check("tie_first_latency", n, 3);
        check("tie_first_rdata", req0_rdata, 32'hDEADBEEF);
        check("tie_first_err", req0_err, 1'b0);
        check("tie_first_not_port1", req1_done, 1'b0);
        wait_done(1, 10, n);
        check("tie_second_gap", n, 4);
        drain(20);

        // Port 1 write then read back, with the one-cycle gap between them.
        issue(1, 1'b0, 16'h0020, 32'h12345678, DD);
        wait_done(1, 10, n);
        check("write_latency", n, 3);
        issue(1, 1'b1, 16'h0020, '0, DD);
        wait_done(1, 10, n);
        check("readback_latency", n, 4);
        check("readback_rdata", req1_rdata, 32'h12345678);

        // Continuous contention: grants alternate, four cycles apart.
        issue(0, 1'b1, 16'h0010, '0, DD);
        issue(1, 1'b1, 16'h0020, '0, DD);
        got = 0;
        last_cyc = 0;
        for (int k = 0; k < 60 && got < 8; k++) begin
            step();
            if (dut_done != 2'b00) begin
                first_port = dut_done[1] ? 1 : 0;
                check("contend_port", first_port, got % 2);
                if (got > 0) check("contend_spacing", cyc - last_cyc, 4);
                last_cyc = cyc;
                got++;
                if (got < 7) issue(first_port, 1'b1, first_port ? 16'h0020 : 16'h0010, '0, DD);
            end
        end
        check("contend_count", got, 8);
        drain(20);

        // Timeout: DATA_READY never rises, then a normal read follows.
        issue(0, 1'b1, 16'h0010, '0, 1000);
        wait_done(0, 30, n);
        check("timeout_latency", n, TO + 1);
        check("timeout_err", req0_err, 1'b1);
        check("timeout_rdata", req0_rdata, '0);
        issue(0, 1'b1, 16'h0020, '0, DD);
        wait_done(0, 10, n);
        check("after_timeout_latency", n, 4);
        check("after_timeout_err", req0_err, 1'b0);
        check("after_timeout_rdata", req0_rdata, 32'h12345678);
        drain(20);

        // Reset during the second ACCESS cycle: transaction lost, request re-served afterwards.
        issue(0, 1'b1, 16'h0010, '0, DD);
        step(); step();
        check("pre_reset_enable", mem_enable, 1'b1);
        #2 rst = 1'b1;
        #1 check_all_zero("reset_mid_access");
        step();
        check_all_zero("reset_held");
        @(negedge clk) rst = 1'b0;
        wait_done(0, 10, n);
        check("post_reset_latency", n, 3);
        check("post_reset_rdata", req0_rdata, 32'hDEADBEEF);
        drain(20);

        // Randomized traffic against the model.
        auto_req = 1;
        for (int k = 0; k < 1500; k++) step();
        auto_req = 0;
        drain(200);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
